glb_pe_feeder: RTL and testbench
================================

# glb_pe_feeder

GLB-side transmitter/receiver for the PE array's stream interfaces. It executes one transfer command at a time. For ifmap, filter and ipsum commands it reads words from the dual-port GLB SRAM and streams them onto the GIN valid/ready channels with the command's X/Y tag. For opsum commands it accepts words from the GON channel and writes them back to SRAM. It sits between the layer controller and the PE array and is the producer/consumer counterpart of the array's GIN/GON ports.

## Interface
Parameters:
- DATA_SIZE, 32, stream and SRAM word width
- ADDR_BITS, 12, SRAM word-address width
- LEN_BITS, 10, transfer length width in words
- XID_BITS, 5, X tag width
- YID_BITS, 3, Y tag width

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  feeder idle and can accept a command
- cmd_type  in  2  0 = ifmap, 1 = filter, 2 = ipsum, 3 = opsum
- cmd_addr  in  ADDR_BITS  SRAM start word address
- cmd_len  in  LEN_BITS  number of words
- cmd_tag_X  in  XID_BITS  X tag for the transfer
- cmd_tag_Y  in  YID_BITS  Y tag for the transfer
- done  out  1  one-cycle pulse when the command completes
- tag_X  out  XID_BITS  registered tag, held for the whole command
- tag_Y  out  YID_BITS  registered tag, held for the whole command
- GLB_ifmap_valid, GLB_filter_valid, GLB_ipsum_valid  out  1 each  per-type send valid
- GLB_ifmap_ready, GLB_filter_ready, GLB_ipsum_ready  in  1 each  per-type send ready
- GLB_data_in  out  DATA_SIZE  send data, shared by all three send types
- GLB_opsum_valid  in  1  opsum word offered
- GLB_opsum_ready  out  1  feeder accepts opsum
- GLB_data_out  in  DATA_SIZE  opsum data
- mem_ren  out  1  SRAM read enable
- mem_raddr  out  ADDR_BITS  SRAM read address
- mem_rdata  in  DATA_SIZE  SRAM read data, valid one cycle after mem_ren
- mem_wen  out  1  SRAM write enable
- mem_waddr  out  ADDR_BITS  SRAM write address
- mem_wdata  out  DATA_SIZE  SRAM write data
- stall_cnt  out  32  backpressure stall counter (see Configuration)

## Operation
- FSM states: IDLE, SEND, RECV, DONE.
- IDLE:
  - cmd_ready = 1.
  - A cmd_valid&&cmd_ready handshake latches type, addr, len and tags.
  - len = 0 → DONE. Type 3 → RECV. Otherwise → SEND.
- SEND:
  - A read issuer walks the addresses from addr to addr+len−1.
  - Read data lands in a 2-entry FIFO.
  - A read is issued only when (FIFO occupancy + reads in flight) < 2, so the FIFO never overflows under backpressure.
  - Only the valid line matching the latched type is driven, as FIFO non-empty. GLB_data_in = FIFO head.
  - A handshake on the active type pops the FIFO and increments sent_cnt.
  - sent_cnt == len → DONE.
- RECV:
  - GLB_opsum_ready = 1.
  - Each GLB_opsum_valid handshake registers a write: mem_wen = 1 the next cycle, mem_waddr = addr + recv_cnt, mem_wdata = the data.
  - After the last handshake → DONE.
- DONE: done = 1 for one cycle → IDLE.
- Address arithmetic wraps modulo 2^ADDR_BITS. A transfer crossing the top address continues from address 0.
- Valid, once asserted, is held with stable GLB_data_in until ready. Valid is never deasserted without a handshake.
- Commands offered while cmd_ready = 0 are ignored.

## Timing
- Reset values:
  - All outputs 0: cmd_ready = 0 during reset, then 1 in IDLE.
  - tag_X/tag_Y = 0.
  - FIFO is empty and all counters are 0.
- Send path:
  - Cycle T: command accepted.
  - T+1: first mem_ren.
  - T+2: first valid.
  - With ready held high, one word per cycle.
  - Last handshake at cycle L → done at L+1 → cmd_ready at L+2.
- Receive path:
  - Last opsum handshake at L → final mem_wen at L+1 → done at L+2.
- len = 0: done at T+1, with no stream or SRAM activity.
- Ready deasserted with the FIFO full: mem_ren stays 0 until a pop.
  - A pop and a read return in the same cycle leave occupancy unchanged.
- Asynchronous reset mid-command aborts the transfer, flushes the FIFO and drops any pending write. No done pulse is produced.

## Configuration
- FEEDER_PERF_CNT_EN defined:
  - stall_cnt increments every cycle in which the active send valid = 1 and ready = 0, or in RECV with GLB_opsum_valid = 0.
  - stall_cnt saturates at 2^32−1.
  - stall_cnt clears on command acceptance.
- Macro undefined: stall_cnt is tied to 0 and no counter logic is built.

## Test plan
- Filter send: addr = 0x010, len = 4, tags (3,2), ready always high, SRAM[0x10..0x13] = 1..4.
  - → GLB_filter_valid high for 4 consecutive cycles starting T+2, data 1,2,3,4.
  - → tag_X = 3, tag_Y = 2 throughout.
  - → done at T+6.
  - → the ifmap and ipsum valids stay 0.
- Backpressure: ifmap, len = 6, GLB_ifmap_ready toggled 1,0,0,1,… 
  - → data order is preserved and data is stable while stalled.
  - → mem_ren never has more than 2 words outstanding or buffered.
  - → exactly 6 handshakes.
- Opsum receive: addr = 0xFFE, len = 3, data A,B,C.
  - → writes to 0xFFE, 0xFFF, 0x000 with A,B,C, each one cycle after its handshake.
  - → done 2 cycles after the last handshake.
- Zero length: cmd_len = 0, any type → done at T+1, with no valid, mem_ren or mem_wen.
- Reset mid-send: assert rst after 2 of 5 ipsum words.
  - → all outputs 0 immediately.
  - → after release, cmd_ready = 1 and a new command runs cleanly.
- Perf counter with FEEDER_PERF_CNT_EN: a send with 7 stalled cycles → stall_cnt = 7 at done. Without the macro, stall_cnt = 0.

Source files
------------

// File: rtl/glb_pe_feeder.sv
// glb_pe_feeder: GLB-side GIN sender / GON receiver, one command at a time.
// Optional FEEDER_PERF_CNT_EN builds the backpressure stall counter.
module glb_pe_feeder #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_BITS = 12,
  parameter int LEN_BITS  = 10,
  parameter int XID_BITS  = 5,
  parameter int YID_BITS  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_type,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  input  logic [LEN_BITS-1:0]  cmd_len,
  input  logic [XID_BITS-1:0]  cmd_tag_X,
  input  logic [YID_BITS-1:0]  cmd_tag_Y,
  output logic                 done,
  output logic [XID_BITS-1:0]  tag_X,
  output logic [YID_BITS-1:0]  tag_Y,
  output logic                 GLB_ifmap_valid,
  output logic                 GLB_filter_valid,
  output logic                 GLB_ipsum_valid,
  input  logic                 GLB_ifmap_ready,
  input  logic                 GLB_filter_ready,
  input  logic                 GLB_ipsum_ready,
  output logic [DATA_SIZE-1:0] GLB_data_in,
  input  logic                 GLB_opsum_valid,
  output logic                 GLB_opsum_ready,
  input  logic [DATA_SIZE-1:0] GLB_data_out,
  output logic                 mem_ren,
  output logic [ADDR_BITS-1:0] mem_raddr,
  input  logic [DATA_SIZE-1:0] mem_rdata,
  output logic                 mem_wen,
  output logic [ADDR_BITS-1:0] mem_waddr,
  output logic [DATA_SIZE-1:0] mem_wdata,
  output logic [31:0]          stall_cnt
);
  typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;
  state_t state;
  logic [1:0] typ;
  logic [ADDR_BITS-1:0] addr;
  logic [LEN_BITS-1:0] len, issued, sent, recvd;
  logic inflight, rp, wp;
  logic [1:0] occ;
  logic [DATA_SIZE-1:0] fifo [2];
  logic avail, send_v, act_ready, pop, pop_buf, push, opsum_hs;
  // A word returning from SRAM is offered straight away and only buffered if not taken.
  assign avail     = occ != 2'd0 || inflight;
  assign send_v    = state == SEND && avail;
  assign act_ready = typ == 2'd0 ? GLB_ifmap_ready : typ == 2'd1 ? GLB_filter_ready : GLB_ipsum_ready;
  assign pop       = send_v && act_ready;
  assign pop_buf   = pop && occ != 2'd0;
  assign push      = inflight && !(pop && occ == 2'd0);
  assign mem_ren   = state == SEND && issued != len && (occ + 2'(inflight)) < 2'd2;
  assign mem_raddr = addr + ADDR_BITS'(issued);
  assign GLB_data_in      = occ != 2'd0 ? fifo[rp] : inflight ? mem_rdata : '0;
  assign GLB_ifmap_valid  = send_v && typ == 2'd0;
  assign GLB_filter_valid = send_v && typ == 2'd1;
  assign GLB_ipsum_valid  = send_v && typ == 2'd2;
  assign GLB_opsum_ready  = state == RECV && recvd != len;
  assign opsum_hs         = GLB_opsum_valid && GLB_opsum_ready;
  assign done             = state == DONE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      typ       <= '0;
      addr      <= '0;
      len       <= '0;
      tag_X     <= '0;
      tag_Y     <= '0;
      issued    <= '0;
      sent      <= '0;
      recvd     <= '0;
      inflight  <= 1'b0;
      occ       <= '0;
      rp        <= 1'b0;
      wp        <= 1'b0;
      fifo[0]   <= '0;
      fifo[1]   <= '0;
      mem_wen   <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
    end else begin
      inflight <= mem_ren;
      if (mem_ren) issued <= issued + LEN_BITS'(1);
      if (push) begin
        fifo[wp] <= mem_rdata;
        wp       <= ~wp;
      end
      if (pop_buf) rp <= ~rp;
      occ <= occ + 2'(push) - 2'(pop_buf);
      if (pop) sent <= sent + LEN_BITS'(1);
      mem_wen <= opsum_hs;
      if (opsum_hs) begin
        mem_waddr <= addr + ADDR_BITS'(recvd);
        mem_wdata <= GLB_data_out;
        recvd     <= recvd + LEN_BITS'(1);
      end
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            typ       <= cmd_type;
            addr      <= cmd_addr;
            len       <= cmd_len;
            tag_X     <= cmd_tag_X;
            tag_Y     <= cmd_tag_Y;
            issued    <= '0;
            sent      <= '0;
            recvd     <= '0;
            cmd_ready <= 1'b0;
            state     <= cmd_len == '0 ? DONE : cmd_type == 2'd3 ? RECV : SEND;
          end
        end
        SEND: if (pop && sent + LEN_BITS'(1) == len) state <= DONE;
        RECV: if (recvd == len) state <= DONE;
        DONE: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef FEEDER_PERF_CNT_EN
  logic [31:0] stall;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall <= '0;
    else if (state == IDLE && cmd_valid && cmd_ready) stall <= '0;
    else if (((send_v && !act_ready) || (state == RECV && !GLB_opsum_valid)) && stall != '1) stall <= stall + 32'd1;
  end
  assign stall_cnt = stall;
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_glb_pe_feeder.sv
// tb_glb_pe_feeder: directed vector table plus receive and reset sequences for glb_pe_feeder.
module tb_glb_pe_feeder;
  logic clk = 1'b0, rst = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, done;
  logic [1:0] cmd_type = '0;
  logic [11:0] cmd_addr = '0;
  logic [9:0] cmd_len = '0;
  logic [4:0] cmd_tag_X = '0, tag_X;
  logic [2:0] cmd_tag_Y = '0, tag_Y;
  logic GLB_ifmap_valid, GLB_filter_valid, GLB_ipsum_valid;
  logic GLB_ifmap_ready = 1'b0, GLB_filter_ready = 1'b0, GLB_ipsum_ready = 1'b0;
  logic [31:0] GLB_data_in, GLB_data_out = '0, mem_rdata = '0, mem_wdata, stall_cnt;
  logic GLB_opsum_valid = 1'b0, GLB_opsum_ready, mem_ren, mem_wen;
  logic [11:0] mem_raddr, mem_waddr;
  logic [31:0] sram [4096];
  int checks = 0, fails = 0;

  glb_pe_feeder dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_tag_X(cmd_tag_X), .cmd_tag_Y(cmd_tag_Y),
    .done(done), .tag_X(tag_X), .tag_Y(tag_Y), .GLB_ifmap_valid(GLB_ifmap_valid),
    .GLB_filter_valid(GLB_filter_valid), .GLB_ipsum_valid(GLB_ipsum_valid),
    .GLB_ifmap_ready(GLB_ifmap_ready), .GLB_filter_ready(GLB_filter_ready),
    .GLB_ipsum_ready(GLB_ipsum_ready), .GLB_data_in(GLB_data_in),
    .GLB_opsum_valid(GLB_opsum_valid), .GLB_opsum_ready(GLB_opsum_ready),
    .GLB_data_out(GLB_data_out), .mem_ren(mem_ren), .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata), .mem_wen(mem_wen), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_word(input logic [11:0] a);
    return 32'(a) - 32'd15;
  endfunction

  // SRAM model: preloaded while reset is held, one-cycle read latency.
  always @(posedge clk) begin
    if (!rst) for (int i = 0; i < 4096; i++) sram[i] <= exp_word(12'(i));
    else begin
      if (mem_ren) mem_rdata <= sram[mem_raddr];
      if (mem_wen) sram[mem_waddr] <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] t; logic [11:0] a; logic [9:0] n; logic [4:0] tx; logic [2:0] ty;
    logic [7:0] rp; int done_at; int hs; int stall;
  } vec_t;

  task automatic run_cmd(input vec_t v, output int done_at, output int hs, output int rens,
                         output int bad, output logic [31:0] st);
    logic pv, vld, r;
    logic [31:0] pd;
    done_at = -1; hs = 0; rens = 0; bad = 0; st = '0; pv = 1'b0; pd = '0;
    @(negedge clk);
    if (cmd_ready !== 1'b1) bad++;
    cmd_valid = 1'b1; cmd_type = v.t; cmd_addr = v.a; cmd_len = v.n;
    cmd_tag_X = v.tx; cmd_tag_Y = v.ty;
    for (int k = 1; k < 200 && done_at < 0; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      r = v.rp[k % 8];
      GLB_ifmap_ready = r; GLB_filter_ready = r; GLB_ipsum_ready = r;
      vld = v.t == 2'd0 ? GLB_ifmap_valid : v.t == 2'd1 ? GLB_filter_valid :
            v.t == 2'd2 ? GLB_ipsum_valid : 1'b0;
      if ((GLB_ifmap_valid && v.t != 2'd0) || (GLB_filter_valid && v.t != 2'd1) ||
          (GLB_ipsum_valid && v.t != 2'd2) || mem_wen) bad++;
      if (tag_X !== v.tx || tag_Y !== v.ty) bad++;
      if (pv && (!vld || GLB_data_in !== pd)) bad++;
      if (mem_ren) rens++;
      if (rens - hs > 2) bad++;
      if (done) begin
        done_at = k;
        st = stall_cnt;
      end else if (vld && r) begin
        chk("send_data", GLB_data_in, exp_word(v.a + 12'(hs)));
        hs++;
      end
      pv = vld && !r; pd = GLB_data_in;
    end
    @(negedge clk);
    if (done !== 1'b0 || cmd_ready !== 1'b1) bad++;
    GLB_ifmap_ready = 1'b0; GLB_filter_ready = 1'b0; GLB_ipsum_ready = 1'b0;
  endtask

  task automatic check_vec(input vec_t v);
    int d, h, rn, b;
    logic [31:0] st, exp_st;
`ifdef FEEDER_PERF_CNT_EN
    exp_st = 32'(v.stall);
`else
    exp_st = '0;
`endif
    run_cmd(v, d, h, rn, b, st);
    chk("done_cycle", 32'(d), 32'(v.done_at));
    chk("handshakes", 32'(h), 32'(v.hs));
    chk("mem_reads", 32'(rn), 32'(v.n));
    chk("protocol_errors", 32'(b), 32'd0);
    chk("stall_cnt", st, exp_st);
  endtask

  vec_t vecs[6];
  logic [31:0] rdat [3];
  logic [11:0] wa [3];

  initial begin
    int j, w;
    logic ov, exp_wen;
    vec_t post;
    vecs[0] = '{2'd1, 12'h010, 10'd4, 5'd3,  3'd2, 8'hFF, 6,  4, 0};
    vecs[1] = '{2'd0, 12'h040, 10'd6, 5'd1,  3'd0, 8'h99, 13, 6, 5};
    vecs[2] = '{2'd2, 12'h0FF, 10'd1, 5'd9,  3'd4, 8'h02, 10, 1, 7};
    vecs[3] = '{2'd0, 12'hFFE, 10'd3, 5'd31, 3'd7, 8'hFF, 5,  3, 0};
    vecs[4] = '{2'd1, 12'h123, 10'd0, 5'd2,  3'd1, 8'hFF, 1,  0, 0};
    vecs[5] = '{2'd3, 12'h200, 10'd0, 5'd4,  3'd3, 8'hFF, 1,  0, 0};
    post    = '{2'd1, 12'h020, 10'd2, 5'd1,  3'd1, 8'hFF, 4,  2, 0};
    rdat = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003};
    wa = '{12'hFFE, 12'hFFF, 12'h000};
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("reset_tags", {24'd0, tag_X, tag_Y}, 32'd0);
    chk("reset_data", GLB_data_in, 32'd0);
    chk("reset_stall", stall_cnt, 32'd0);
    rst = 1'b1;
    foreach (vecs[i]) check_vec(vecs[i]);

    // opsum receive across the top address, with a gap between the 2nd and 3rd word
    @(negedge clk);
    chk("recv_accept", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_type = 2'd3; cmd_addr = 12'hFFE; cmd_len = 10'd3;
    cmd_tag_X = 5'd2; cmd_tag_Y = 3'd5;
    j = 0; w = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      ov = k == 1 || k == 2 || k == 4;
      GLB_opsum_valid = ov;
      GLB_data_out = ov ? rdat[j] : 32'd0;
      exp_wen = k == 2 || k == 3 || k == 5;
      chk("recv_wen", 32'(mem_wen), 32'(exp_wen));
      if (exp_wen) begin
        chk("recv_waddr", 32'(mem_waddr), 32'(wa[w]));
        chk("recv_wdata", mem_wdata, rdat[w]);
        w++;
      end
      chk("recv_done", 32'(done), 32'(k == 6));
      if (ov) begin
        chk("recv_ready", 32'(GLB_opsum_ready), 32'd1);
        j++;
      end
    end
    GLB_opsum_valid = 1'b0;

    // reset after two of five ipsum words
    @(negedge clk);
    cmd_valid = 1'b1; cmd_type = 2'd2; cmd_addr = 12'h100; cmd_len = 10'd5;
    cmd_tag_X = 5'd4; cmd_tag_Y = 3'd1;
    GLB_ipsum_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (k >= 2) begin
        chk("mid_valid", 32'(GLB_ipsum_valid), 32'd1);
        chk("mid_data", GLB_data_in, exp_word(12'h100 + 12'(k - 2)));
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_valid", 32'(GLB_ipsum_valid), 32'd0);
    chk("abort_ren", 32'(mem_ren), 32'd0);
    chk("abort_data", GLB_data_in, 32'd0);
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("abort_tags", {24'd0, tag_X, tag_Y}, 32'd0);
    chk("abort_wen", 32'(mem_wen), 32'd0);
    @(negedge clk);
    chk("abort_no_done", 32'(done), 32'd0);
    GLB_ipsum_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", 32'(cmd_ready), 32'd1);
    chk("post_reset_done", 32'(done), 32'd0);
    check_vec(post);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
